fifo_stream_reader: RTL and testbench



---
 rtl/fifo_stream_reader.sv | 101 ++++++++++
 tb/tb_fifo_stream_reader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Read-side consumer for a single-clock FIFO (scfifo port style). Issues
//   FIFO reads, absorbs the FIFO read latency in a 3-entry circular buffer
//   and re-presents the words as a valid/ready stream. fifo_rdreq_o never
//   depends on ready_i, so there is no combinational path sink -> FIFO.
//
// Parameters
//   DWIDTH     data word width (must match the FIFO)
//   SHOWAHEAD  "OFF": q valid the cycle after rdreq
//              "ON" : q shows the head word while !empty, rdreq acknowledges
//
// Ports
//   clk_i         clock, rising edge
//   arst_n_i      asynchronous active-low reset
//   flush_i       synchronous flush of buffered and in-flight words
//   fifo_rdreq_o  FIFO read request
//   fifo_q_i      FIFO read data
//   fifo_empty_i  FIFO empty flag
//   data_o        stream data (buffer head)
//   valid_o       data_o holds a valid word
//   ready_i       sink accepts the word when valid_o && ready_i
//   level_o       words held in the output buffer (0..3)
module fifo_stream_reader #(
  parameter int unsigned DWIDTH    = 8,
  parameter string       SHOWAHEAD = "OFF"
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              flush_i,
  output logic              fifo_rdreq_o,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [1:0]        level_o
);

  if (SHOWAHEAD != "OFF" && SHOWAHEAD != "ON") begin : g_bad_showahead
    $error("fifo_stream_reader: SHOWAHEAD must be \"OFF\" or \"ON\"");
  end

  localparam bit SHOW = (SHOWAHEAD == "ON");

  logic [1:0]        cnt;
  logic              infl;
  logic [1:0]        rd_ptr;
  logic [1:0]        wr_ptr;
  logic [DWIDTH-1:0] mem [3];
  logic              capture;
  logic              pop;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Requests are limited by committed space (buffered + in flight), which
  // keeps the request free of any dependence on ready_i. Reset gates it so
  // the request drops immediately on an asynchronous reset.
  always_comb begin
    fifo_rdreq_o = arst_n_i && !fifo_empty_i && !flush_i &&
                   (({1'b0, cnt} + {2'b00, infl}) < 3'd3);
  end

  // OFF: data arrives one cycle after the request; ON: with the request.
  always_comb begin
    capture = SHOW ? fifo_rdreq_o : infl;
    pop     = valid_o && ready_i;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt    <= '0;
      infl   <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int unsigned i = 0; i < 3; i++) mem[i] <= '0;
    end else if (flush_i) begin
      // Data landing this edge from last cycle's read is dropped.
      cnt    <= '0;
      infl   <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      infl <= SHOW ? 1'b0 : fifo_rdreq_o;
      if (capture) begin
        mem[wr_ptr] <= fifo_q_i;
        wr_ptr      <= inc3(wr_ptr);
      end
      if (pop) rd_ptr <= inc3(rd_ptr);
      cnt <= cnt + {1'b0, capture} - {1'b0, pop};
    end
  end

  always_comb begin
    valid_o = (cnt != 2'd0);
    level_o = cnt;
    data_o  = mem[rd_ptr];
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: one instance per SHOWAHEAD mode (0 = OFF,
// 1 = ON), each fed by a behavioural scfifo model. Expected stream contents
// come from a queue of written words; a flush or reset rebuilds it from the
// words still inside the FIFO.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       flush  [2] = '{1'b0, 1'b0};
  logic       ready  [2] = '{1'b0, 1'b0};
  logic       rdreq  [2];
  logic [7:0] fq_q   [2] = '{8'h00, 8'h00};
  logic       fempty [2] = '{1'b1, 1'b1};
  logic [7:0] data   [2];
  logic       valid  [2];
  logic [1:0] level  [2];

  logic [7:0] fq   [2][$];
  logic [7:0] pend [2][$];
  logic [7:0] exp  [2][$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DWIDTH(8), .SHOWAHEAD("OFF")) u_off (
    .clk_i(clk), .arst_n_i(arst_n), .flush_i(flush[0]),
    .fifo_rdreq_o(rdreq[0]), .fifo_q_i(fq_q[0]), .fifo_empty_i(fempty[0]),
    .data_o(data[0]), .valid_o(valid[0]), .ready_i(ready[0]), .level_o(level[0])
  );

  fifo_stream_reader #(.DWIDTH(8), .SHOWAHEAD("ON")) u_on (
    .clk_i(clk), .arst_n_i(arst_n), .flush_i(flush[1]),
    .fifo_rdreq_o(rdreq[1]), .fifo_q_i(fq_q[1]), .fifo_empty_i(fempty[1]),
    .data_o(data[1]), .valid_o(valid[1]), .ready_i(ready[1]), .level_o(level[1])
  );

  // scfifo models: writes (pend) land at the edge; k=0 registered q, k=1 show-ahead
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rdreq[k] && fq[k].size() > 0) begin
        if (k == 0) fq_q[k] <= fq[k].pop_front();
        else void'(fq[k].pop_front());
      end
      while (pend[k].size() > 0) fq[k].push_back(pend[k].pop_front());
      fempty[k] <= (fq[k].size() == 0);
      if (k == 1) fq_q[k] <= (fq[k].size() > 0) ? fq[k][0] : 8'h00;
    end
  end

  task automatic push(input int k, input logic [7:0] v);
    pend[k].push_back(v);
    exp[k].push_back(v);
  endtask

  task automatic rebuild_exp(input int k);
    exp[k].delete();
    for (int i = 0; i < fq[k].size(); i++) exp[k].push_back(fq[k][i]);
    for (int i = 0; i < pend[k].size(); i++) exp[k].push_back(pend[k][i]);
  endtask

  // Leaves time at posedge+1, the drive point used by every test.
  task automatic apply_reset();
    arst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      flush[k] = 1'b0;
      ready[k] = 1'b0;
      fq[k].delete();
      pend[k].delete();
      exp[k].delete();
    end
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    push(0, 8'h5A);
    push(1, 8'hC3);
    arst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++; if (rdreq[k] !== 1'b0) begin bad++; $display("FAIL reset_rdreq k=%0d got=%b exp=0", k, rdreq[k]); end
      total++; if (valid[k] !== 1'b0) begin bad++; $display("FAIL reset_valid k=%0d got=%b exp=0", k, valid[k]); end
      total++; if (level[k] !== 2'd0) begin bad++; $display("FAIL reset_level k=%0d got=%0d exp=0", k, level[k]); end
      total++; if (data[k] !== 8'h00) begin bad++; $display("FAIL reset_data k=%0d got=%h exp=00", k, data[k]); end
    end
    @(posedge clk); #1 arst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++; if (rdreq[k] !== 1'b1) begin bad++; $display("FAIL reset_release_rdreq k=%0d got=%b exp=1", k, rdreq[k]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] expv [3];
    int first_rd, first_v, nv, lastv;
    expv = '{8'h11, 8'h22, 8'h33};
    apply_reset();
    ready[0] = 1'b1;
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
    first_rd = -1; first_v = -1; nv = 0; lastv = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdreq[0] && first_rd < 0) first_rd = i;
      if (valid[0]) begin
        if (first_v < 0) first_v = i;
        total++;
        if (nv > 2) begin bad++; $display("FAIL basic_extra got=%h exp=none", data[0]); end
        else if (data[0] !== expv[nv]) begin bad++; $display("FAIL basic_data idx=%0d got=%h exp=%h", nv, data[0], expv[nv]); end
        lastv = i;
        nv++;
      end
      @(posedge clk); #1;
    end
    total++; if (first_rd < 0 || first_v - first_rd != 2) begin bad++; $display("FAIL basic_latency got=%0d exp=2", first_v - first_rd); end
    total++; if (nv != 3) begin bad++; $display("FAIL basic_count got=%0d exp=3", nv); end
    total++; if (lastv - first_v != 2) begin bad++; $display("FAIL basic_consecutive got=%0d exp=2", lastv - first_v); end
    total++; if (level[0] !== 2'd0) begin bad++; $display("FAIL basic_level got=%0d exp=0", level[0]); end
  endtask

  task automatic test_showahead();
    int first_rd, first_v, npulse, nv;
    apply_reset();
    ready[1] = 1'b1;
    push(1, 8'hA5);
    first_rd = -1; first_v = -1; npulse = 0; nv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rdreq[1]) begin npulse++; if (first_rd < 0) first_rd = i; end
      if (valid[1]) begin
        nv++;
        if (first_v < 0) first_v = i;
        total++; if (data[1] !== 8'hA5) begin bad++; $display("FAIL sa_data got=%h exp=a5", data[1]); end
      end
      @(posedge clk); #1;
    end
    total++; if (npulse != 1) begin bad++; $display("FAIL sa_rdreq_pulses got=%0d exp=1", npulse); end
    total++; if (nv != 1) begin bad++; $display("FAIL sa_valid_cycles got=%0d exp=1", nv); end
    total++; if (first_rd < 0 || first_v - first_rd != 1) begin bad++; $display("FAIL sa_latency got=%0d exp=1", first_v - first_rd); end
  endtask

  task automatic test_backpressure();
    int npulse, got, gaps;
    bit started;
    apply_reset();
    for (int i = 0; i < 16; i++) push(0, 8'($urandom));
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdreq[0]) npulse++;
      if (i >= 7) begin
        total++; if (level[0] !== 2'd3) begin bad++; $display("FAIL bp_level_hold cyc=%0d got=%0d exp=3", i, level[0]); end
      end
      @(posedge clk); #1;
    end
    total++; if (npulse != 3) begin bad++; $display("FAIL bp_rdreq_pulses got=%0d exp=3", npulse); end
    ready[0] = 1'b1;
    got = 0; gaps = 0; started = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid[0]) begin
        started = 1'b1;
        total++;
        if (exp[0].size() == 0) begin bad++; $display("FAIL bp_extra got=%h exp=none", data[0]); end
        else begin
          logic [7:0] e;
          e = exp[0].pop_front();
          if (data[0] !== e) begin bad++; $display("FAIL bp_order idx=%0d got=%h exp=%h", got, data[0], e); end
        end
        got++;
      end else if (started && got < 16) gaps++;
      @(posedge clk); #1;
    end
    total++; if (got != 16) begin bad++; $display("FAIL bp_count got=%0d exp=16", got); end
    total++; if (gaps != 0) begin bad++; $display("FAIL bp_gaps got=%0d exp=0", gaps); end
  endtask

  task automatic test_flush();
    logic [7:0] wv [8];
    bit found;
    int got;
    apply_reset();
    for (int i = 0; i < 8; i++) begin wv[i] = 8'($urandom); push(0, wv[i]); end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (rdreq[0]) found = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (!found) begin bad++; $display("FAIL flush_start got=no_rdreq exp=rdreq"); end
    repeat (2) @(posedge clk);
    #1 flush[0] = 1'b1;
    @(negedge clk);
    total++; if (level[0] !== 2'd2) begin bad++; $display("FAIL flush_pre_level got=%0d exp=2", level[0]); end
    @(posedge clk); #1;
    flush[0] = 1'b0;
    ready[0] = 1'b1;
    @(negedge clk);
    total++; if (valid[0] !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", valid[0]); end
    total++; if (level[0] !== 2'd0) begin bad++; $display("FAIL flush_level got=%0d exp=0", level[0]); end
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid[0]) begin
        total++;
        if (got > 4) begin bad++; $display("FAIL flush_extra got=%h exp=none", data[0]); end
        else if (data[0] !== wv[3 + got]) begin bad++; $display("FAIL flush_order idx=%0d got=%h exp=%h", got, data[0], wv[3 + got]); end
        got++;
      end
      @(posedge clk); #1;
      @(negedge clk);
    end
    total++; if (got != 5) begin bad++; $display("FAIL flush_count got=%0d exp=5", got); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int got;
    logic [7:0] e;
    apply_reset();
    ready[0] = 1'b1;
    for (int i = 0; i < 10; i++) push(0, 8'($urandom));
    got = 0;
    for (int i = 0; i < 20 && got < 3; i++) begin
      @(negedge clk);
      if (valid[0]) begin
        e = exp[0].pop_front();
        total++; if (data[0] !== e) begin bad++; $display("FAIL areset_pre_order got=%h exp=%h", data[0], e); end
        got++;
      end
      @(posedge clk); #1;
    end
    #2 arst_n = 1'b0;
    #1;
    total++; if (valid[0] !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b exp=0", valid[0]); end
    total++; if (rdreq[0] !== 1'b0) begin bad++; $display("FAIL areset_rdreq got=%b exp=0", rdreq[0]); end
    total++; if (level[0] !== 2'd0) begin bad++; $display("FAIL areset_level got=%0d exp=0", level[0]); end
    rebuild_exp(0);
    @(posedge clk); #1 arst_n = 1'b1;
    got = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (valid[0]) begin
        total++;
        if (exp[0].size() == 0) begin bad++; $display("FAIL areset_extra got=%h exp=none", data[0]); end
        else begin
          e = exp[0].pop_front();
          if (data[0] !== e) begin bad++; $display("FAIL areset_order idx=%0d got=%h exp=%h", got, data[0], e); end
        end
        got++;
      end
      @(posedge clk); #1;
    end
    total++; if (got == 0 || exp[0].size() != 0) begin bad++; $display("FAIL areset_resume got=%0d left=%0d exp_left=0", got, exp[0].size()); end
  endtask

  task automatic test_random();
    logic [7:0] e;
    apply_reset();
    for (int c = 0; c < 900; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (c < 600) begin
          ready[k] = 1'($urandom_range(0, 1));
          flush[k] = ($urandom_range(0, 63) == 0);
          if ($urandom_range(0, 9) < 4) push(k, 8'($urandom));
        end else begin
          ready[k] = 1'b1;
          flush[k] = 1'b0;
        end
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        total++; if (rdreq[k] && fempty[k]) begin bad++; $display("FAIL rnd_rdreq_empty k=%0d cyc=%0d got=1 exp=0", k, c); end
        total++; if (valid[k] !== (level[k] != 2'd0)) begin bad++; $display("FAIL rnd_valid_level k=%0d got=%b level=%0d", k, valid[k], level[k]); end
        if (valid[k] && ready[k]) begin
          total++;
          if (exp[k].size() == 0) begin bad++; $display("FAIL rnd_extra k=%0d got=%h exp=none", k, data[k]); end
          else begin
            e = exp[k].pop_front();
            if (data[k] !== e) begin bad++; $display("FAIL rnd_order k=%0d cyc=%0d got=%h exp=%h", k, c, data[k], e); end
          end
        end
        if (flush[k]) rebuild_exp(k);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 2; k++) begin
      total++; if (exp[k].size() != 0) begin bad++; $display("FAIL rnd_drain k=%0d got_left=%0d exp=0", k, exp[k].size()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_showahead();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
